// File: rtl/tft_monitor_pkg.sv
// Shared constants and types for the TFT frame monitor: register map,
// CONTROL/STATUS bit positions, counter width and the checksum step.
package tft_monitor_pkg;

  // Width of the pixel and line counters (saturating)
  localparam int unsigned CNT_WIDTH = 16;

  // Register word indices (wbs_adr_i[2:0])
  localparam logic [2:0] REG_CONTROL     = 3'd0;
  localparam logic [2:0] REG_STATUS      = 3'd1;
  localparam logic [2:0] REG_PPL         = 3'd2;
  localparam logic [2:0] REG_LPF         = 3'd3;
  localparam logic [2:0] REG_CHECKSUM    = 3'd4;
  localparam logic [2:0] REG_FRAME_COUNT = 3'd5;

  // CONTROL bit positions
  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT  = 1;
  localparam int unsigned CTRL_INT_EN_BIT = 2;

  // STATUS bit positions
  localparam int unsigned STAT_LOCKED_BIT     = 0;
  localparam int unsigned STAT_FRAME_DONE_BIT = 1;
  localparam int unsigned STAT_MISMATCH_BIT   = 2;
  localparam int unsigned STAT_OVERFLOW_BIT   = 3;

  // STATUS layout; first member is the MSB so locked lands on bit 0
  typedef struct packed {
    logic overflow;
    logic line_mismatch;
    logic frame_done;
    logic locked;
  } status_t;

  // One checksum step: rotate left by one, then fold in the pixel
  function automatic logic [31:0] checksum_step(input logic [31:0] sum,
                                                input logic [23:0] rgb);
    return {sum[30:0], sum[31]} ^ {8'h00, rgb};
  endfunction

endpackage

// File: rtl/tft_video_sampler.sv
// Front end of the frame monitor: detects pclk rising edges in the clk
// domain, registers the video inputs alongside the strobe and normalises
// the sync polarity so downstream logic only sees "active" levels.
module tft_video_sampler
  import tft_monitor_pkg::*;
#(
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pclk_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        data_en_i,
  input  logic [7:0]  red_i,
  input  logic [7:0]  green_i,
  input  logic [7:0]  blue_i,
  output logic        pix_stb_o,
  output logic        de_o,
  output logic        de_fall_o,
  output logic        vs_start_o,
  output logic [23:0] rgb_o
);

  logic        pclk_q;
  logic        pix_stb_q;
  logic        de_q;
  logic        de_fall_q;
  logic        vs_start_q;
  logic        hs_q;
  logic        de_last_q;
  logic        vs_last_q;
  logic [23:0] rgb_q;

  logic        pix_stb_d;
  logic        vs_act_d;
  logic        unused_hs;

  assign pix_stb_d = pclk_i & ~pclk_q;
  assign vs_act_d  = (vsync_i == SYNC_POL);

  // Horizontal sync is captured for completeness but not measured
  assign unused_hs = hs_q;

  // Edge detect and input capture; de/vsync history advances on strobes only
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_q     <= 1'b0;
      pix_stb_q  <= 1'b0;
      de_q       <= 1'b0;
      de_fall_q  <= 1'b0;
      vs_start_q <= 1'b0;
      hs_q       <= 1'b0;
      de_last_q  <= 1'b0;
      vs_last_q  <= 1'b0;
      rgb_q      <= 24'h000000;
    end else begin
      pclk_q     <= pclk_i;
      pix_stb_q  <= pix_stb_d;
      de_q       <= data_en_i;
      de_fall_q  <= pix_stb_d & de_last_q & ~data_en_i;
      vs_start_q <= pix_stb_d & vs_act_d & ~vs_last_q;
      hs_q       <= (hsync_i == SYNC_POL);
      rgb_q      <= {red_i, green_i, blue_i};
      if (pix_stb_d) begin
        de_last_q <= data_en_i;
        vs_last_q <= vs_act_d;
      end else begin
        de_last_q <= de_last_q;
        vs_last_q <= vs_last_q;
      end
    end
  end

  assign pix_stb_o  = pix_stb_q;
  assign de_o       = de_q;
  assign de_fall_o  = de_fall_q;
  assign vs_start_o = vs_start_q;
  assign rgb_o      = rgb_q;

endmodule

// File: rtl/tft_frame_monitor.sv
// Wishbone-attached TFT stream monitor: counts pixels per line, lines per
// frame and frames, builds a per-frame rotate/xor checksum and exposes the
// results plus sticky status flags and a frame-done interrupt.
module tft_frame_monitor
  import tft_monitor_pkg::*;
#(
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = CNT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_int_o,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic        pclk,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        data_en
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Sampler outputs
  logic        pix_stb_s;
  logic        de_s;
  logic        de_fall_s;
  logic        vs_start_s;
  logic [23:0] rgb_s;

  // Bus handshake
  logic        ack_q,   ack_d;
  logic        done_q,  done_d;
  logic [31:0] dat_q,   dat_d;
  logic        int_q,   int_d;
  logic        req_s;
  logic        wr_s;
  logic        wr_ctrl_s;
  logic        wr_stat_s;
  logic        clear_s;
  logic [31:0] rd_data_s;

  // Control and status
  logic        enable_q, enable_d;
  logic        int_en_q, int_en_d;
  logic        armed_q,  armed_d;
  logic        mm_q,     mm_d;
  status_t     status_q, status_d;

  // Video counters and latched results
  logic [CNT_W-1:0] pix_q,  pix_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [CNT_W-1:0] ppl_q,  ppl_d;
  logic [CNT_W-1:0] lpf_q,  lpf_d;
  logic [CNT_W-1:0] fppl_q, fppl_d;
  logic [31:0]      sum_q,  sum_d;
  logic [31:0]      chk_q,  chk_d;
  logic [31:0]      fcnt_q, fcnt_d;

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[31:3], wbs_dat_i[31:4]};

  tft_video_sampler #(
    .SYNC_POL (SYNC_POL)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .pclk_i     (pclk),
    .hsync_i    (hsync),
    .vsync_i    (vsync),
    .data_en_i  (data_en),
    .red_i      (red),
    .green_i    (green),
    .blue_i     (blue),
    .pix_stb_o  (pix_stb_s),
    .de_o       (de_s),
    .de_fall_o  (de_fall_s),
    .vs_start_o (vs_start_s),
    .rgb_o      (rgb_s)
  );

  // One ack per strobe; done_q blocks re-acking a strobe held past its ack
  assign req_s     = wbs_cyc_i & wbs_stb_i;
  assign ack_d     = req_s & ~ack_q & ~done_q;
  assign done_d    = req_s & (ack_q | done_q);
  assign wr_s      = ack_q & req_s & wbs_we_i;
  assign wr_ctrl_s = wr_s & (wbs_adr_i[2:0] == REG_CONTROL);
  assign wr_stat_s = wr_s & (wbs_adr_i[2:0] == REG_STATUS);
  assign clear_s   = wr_ctrl_s & wbs_dat_i[CTRL_CLEAR_BIT];
  assign dat_d     = ack_d ? rd_data_s : 32'h0000_0000;
  assign int_d     = status_q.frame_done & int_en_q;

  // Register read multiplexer
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (wbs_adr_i[2:0])
      REG_CONTROL: begin
        rd_data_s[CTRL_ENABLE_BIT] = enable_q;
        rd_data_s[CTRL_INT_EN_BIT] = int_en_q;
      end
      REG_STATUS:      rd_data_s = {28'h000_0000, status_q};
      REG_PPL:         rd_data_s = 32'(ppl_q);
      REG_LPF:         rd_data_s = 32'(lpf_q);
      REG_CHECKSUM:    rd_data_s = chk_q;
      REG_FRAME_COUNT: rd_data_s = fcnt_q;
      default:         rd_data_s = 32'h0000_0000;
    endcase
  end

  // Next state: bus writes first, then video events (so a frame_done set
  // beats a same-cycle W1C), then clear on top of everything
  always_comb begin
    enable_d = enable_q;
    int_en_d = int_en_q;
    armed_d  = armed_q;
    mm_d     = mm_q;
    status_d = status_q;
    pix_d    = pix_q;
    line_d   = line_q;
    ppl_d    = ppl_q;
    lpf_d    = lpf_q;
    fppl_d   = fppl_q;
    sum_d    = sum_q;
    chk_d    = chk_q;
    fcnt_d   = fcnt_q;

    if (wr_ctrl_s) begin
      enable_d = wbs_dat_i[CTRL_ENABLE_BIT];
      int_en_d = wbs_dat_i[CTRL_INT_EN_BIT];
    end else begin
      enable_d = enable_q;
    end

    if (wr_stat_s) begin
      status_d.frame_done    = status_q.frame_done    & ~wbs_dat_i[STAT_FRAME_DONE_BIT];
      status_d.line_mismatch = status_q.line_mismatch & ~wbs_dat_i[STAT_MISMATCH_BIT];
      status_d.overflow      = status_q.overflow      & ~wbs_dat_i[STAT_OVERFLOW_BIT];
    end else begin
      status_d = status_q;
    end

    if (enable_q && pix_stb_s) begin
      // Line end is processed before any frame boundary in the same strobe
      if (de_fall_s && (pix_d != CNT_ZERO)) begin
        if ((line_d != CNT_ZERO) && (pix_d != ppl_q)) begin
          status_d.line_mismatch = 1'b1;
          mm_d                   = 1'b1;
        end else begin
          mm_d = mm_d;
        end
        if (line_d == CNT_MAX) begin
          status_d.overflow = 1'b1;
        end else begin
          line_d = line_d + CNT_ONE;
        end
        ppl_d = pix_d;
        pix_d = CNT_ZERO;
      end else begin
        pix_d = pix_d;
      end

      if (de_s) begin
        if (pix_d == CNT_MAX) begin
          status_d.overflow = 1'b1;
        end else begin
          pix_d = pix_d + CNT_ONE;
        end
        sum_d = checksum_step(sum_d, rgb_s);
      end else begin
        sum_d = sum_d;
      end

      if (vs_start_s) begin
        if (armed_q && (line_d != CNT_ZERO)) begin
          lpf_d               = line_d;
          chk_d               = sum_d;
          fcnt_d              = fcnt_q + 32'd1;
          status_d.frame_done = 1'b1;
          status_d.locked     = (line_d == lpf_q) && (ppl_d == fppl_q) && !mm_d;
          fppl_d              = ppl_d;
        end else begin
          lpf_d = lpf_d;
        end
        armed_d = 1'b1;
        sum_d   = 32'h0000_0000;
        line_d  = CNT_ZERO;
        pix_d   = CNT_ZERO;
        mm_d    = 1'b0;
      end else begin
        armed_d = armed_d;
      end
    end else begin
      pix_d = pix_d;
    end

    if (!enable_q) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_d;
    end

    if (clear_s) begin
      armed_d  = 1'b0;
      mm_d     = 1'b0;
      status_d = '0;
      pix_d    = CNT_ZERO;
      line_d   = CNT_ZERO;
      ppl_d    = CNT_ZERO;
      lpf_d    = CNT_ZERO;
      fppl_d   = CNT_ZERO;
      sum_d    = 32'h0000_0000;
      chk_d    = 32'h0000_0000;
      fcnt_d   = 32'h0000_0000;
    end else begin
      status_d = status_d;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      dat_q    <= 32'h0000_0000;
      int_q    <= 1'b0;
      enable_q <= 1'b0;
      int_en_q <= 1'b0;
      armed_q  <= 1'b0;
      mm_q     <= 1'b0;
      status_q <= '0;
      pix_q    <= CNT_ZERO;
      line_q   <= CNT_ZERO;
      ppl_q    <= CNT_ZERO;
      lpf_q    <= CNT_ZERO;
      fppl_q   <= CNT_ZERO;
      sum_q    <= 32'h0000_0000;
      chk_q    <= 32'h0000_0000;
      fcnt_q   <= 32'h0000_0000;
    end else begin
      ack_q    <= ack_d;
      done_q   <= done_d;
      dat_q    <= dat_d;
      int_q    <= int_d;
      enable_q <= enable_d;
      int_en_q <= int_en_d;
      armed_q  <= armed_d;
      mm_q     <= mm_d;
      status_q <= status_d;
      pix_q    <= pix_d;
      line_q   <= line_d;
      ppl_q    <= ppl_d;
      lpf_q    <= lpf_d;
      fppl_q   <= fppl_d;
      sum_q    <= sum_d;
      chk_q    <= chk_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign wbs_int_o = int_q;

endmodule

// File: tb/tb_tft_frame_monitor.sv
// Scoreboard bench for tft_frame_monitor. Bus accesses push their expected
// read data into a queue; a monitor pops and compares on every ack.
// Counters are built 8 bits wide here so saturation is reached in a few
// hundred pixels (saturation value 0xFF instead of 0xFFFF).
module tb_tft_frame_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o, wbs_int_o;
  logic [7:0]  red, green, blue;
  logic        pclk, hsync, vsync, data_en;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  bit          chk_q[$];
  int          adr_q[$];

  always #5 clk = ~clk;

  tft_frame_monitor #(.SYNC_POL(1'b0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o), .wbs_int_o(wbs_int_o),
    .red(red), .green(green), .blue(blue),
    .pclk(pclk), .hsync(hsync), .vsync(vsync), .data_en(data_en)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe held for three cycles so a second ack on the same strobe would
  // find no queue entry and be reported
  task automatic wb_xfer(input bit we, input int adr, input logic [31:0] dat,
                         input logic [31:0] exp, input bit chk);
    exp_q.push_back(exp);
    chk_q.push_back(chk);
    adr_q.push_back(adr);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = 32'(adr); wbs_dat_i = dat;
    tick(); tick(); tick();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    tick();
  endtask

  task automatic rd(input int adr, input logic [31:0] exp);
    wb_xfer(1'b0, adr, 32'h0, exp, 1'b1);
  endtask

  task automatic wr(input int adr, input logic [31:0] dat);
    wb_xfer(1'b1, adr, dat, 32'h0, 1'b0);
  endtask

  task automatic check_int(input logic exp, input string name);
    checks++;
    if (wbs_int_o !== exp) begin
      errors++;
      $display("FAIL %s: wbs_int_o=%b expected %b", name, wbs_int_o, exp);
    end
  endtask

  // One pixel period at pclk = clk/2; vs_act drives vsync active (low)
  task automatic pix(input bit de, input bit vs_act, input logic [23:0] rgb);
    pclk = 1'b0; data_en = de; vsync = vs_act ? 1'b0 : 1'b1;
    {red, green, blue} = rgb;
    tick();
    pclk = 1'b1;
    tick();
  endtask

  task automatic vs_pulse();
    pix(1'b0, 1'b1, 24'h0);
    pix(1'b0, 1'b0, 24'h0);
    pix(1'b0, 1'b0, 24'h0);
  endtask

  task automatic line(input int n, input logic [23:0] rgb);
    for (int i = 0; i < n; i++) pix(1'b1, 1'b0, rgb);
    pix(1'b0, 1'b0, 24'h0);
    pix(1'b0, 1'b0, 24'h0);
  endtask

  // Scoreboard monitor: compare on ack, require zero data otherwise
  always @(negedge clk) begin
    logic [31:0] e;
    bit          c;
    int          a;
    if (!rst) begin
      if (wbs_ack_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: ack=1 with no pending access");
        end else begin
          e = exp_q.pop_front(); c = chk_q.pop_front(); a = adr_q.pop_front();
          if (c) begin
            checks++;
            if (wbs_dat_o !== e) begin
              errors++;
              $display("FAIL rd_reg%0d: got %08h expected %08h", a, wbs_dat_o, e);
            end
          end
        end
      end else begin
        checks++;
        if (wbs_dat_o !== 32'h0) begin
          errors++;
          $display("FAIL dat_idle: got %08h expected 00000000", wbs_dat_o);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    wbs_we_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    red = 8'h0; green = 8'h0; blue = 8'h0;
    pclk = 1'b0; hsync = 1'b1; vsync = 1'b1; data_en = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_int(1'b0, "int_reset");
    for (int r = 0; r < 8; r++) rd(r, 32'h0);

    // Enable with interrupt, three 3x4 frames of rgb=1
    wr(0, 32'h5);
    rd(0, 32'h5);
    for (int f = 0; f < 3; f++) begin
      vs_pulse();
      for (int l = 0; l < 3; l++) line(4, 24'h000001);
    end
    tick(); tick();
    rd(2, 32'd4);
    rd(3, 32'd3);
    rd(4, 32'h0000_0FFF);
    rd(5, 32'd2);
    rd(1, 32'h3);
    check_int(1'b1, "int_after_frames");

    // W1C frame_done
    wr(1, 32'h2);
    rd(1, 32'h1);
    check_int(1'b0, "int_after_w1c");

    // W1C landing on the same edge as a frame latch: set wins
    fork
      vs_pulse();
      begin tick(); wr(1, 32'h2); end
    join
    tick(); tick();
    rd(1, 32'h3);
    rd(5, 32'd3);
    check_int(1'b1, "int_coincident");

    // Mismatching second line: 4,5,4
    line(4, 24'h000001); line(5, 24'h000001); line(4, 24'h000001);
    vs_pulse();
    rd(1, 32'h6);
    rd(2, 32'd4);
    rd(4, 32'h0000_1FFF);
    rd(5, 32'd4);
    wr(1, 32'hE);
    rd(1, 32'h0);

    // Mixed pixel values, 2x2 frame
    pix(1'b1, 1'b0, 24'h123456); pix(1'b1, 1'b0, 24'hABCDEF);
    pix(1'b0, 1'b0, 24'h0);      pix(1'b0, 1'b0, 24'h0);
    pix(1'b1, 1'b0, 24'h000080); pix(1'b1, 1'b0, 24'hFF0000);
    pix(1'b0, 1'b0, 24'h0);      pix(1'b0, 1'b0, 24'h0);
    vs_pulse();
    rd(4, 32'h02C1_940C);
    rd(3, 32'd2);
    rd(2, 32'd2);
    rd(1, 32'h2);

    // 33 pixels: checksum rotation wraps bit 31
    line(33, 24'h000001);
    vs_pulse();
    rd(4, 32'hFFFF_FFFE);
    rd(3, 32'd1);
    rd(2, 32'd33);
    rd(5, 32'd6);

    // Clear mid-frame
    line(3, 24'h000001);
    pix(1'b1, 1'b0, 24'h000001); pix(1'b1, 1'b0, 24'h000001);
    wr(0, 32'h7);
    rd(0, 32'h5);
    for (int r = 1; r < 6; r++) rd(r, 32'h0);
    check_int(1'b0, "int_after_clear");
    line(4, 24'h000001);
    vs_pulse();
    rd(5, 32'd0);
    rd(3, 32'd0);
    line(4, 24'h000001); line(4, 24'h000001);
    vs_pulse();
    rd(5, 32'd1);
    rd(3, 32'd2);
    rd(2, 32'd4);
    rd(4, 32'h0000_00FF);
    rd(1, 32'h2);

    // Pixel counter saturation
    line(300, 24'h010203);
    rd(1, 32'hA);
    rd(2, 32'h0000_00FF);

    tick(); tick(); tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_ack: %0d accesses never acked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
